// File: rtl/scan_counter_n_if.sv
// Shared command-bus view of the scan counter register block.
// Byte path: addr/data/write; word path: data32/write32 (same addr); read byte: data_out.
// master = command block side, slave = scan_counter_n side; no backpressure, writes are single-cycle strobes.
interface scan_counter_n_if;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        write;
    logic [31:0] data32;
    logic        write32;
    logic [7:0]  data_out;

    modport master (output addr, data, write, data32, write32, input  data_out);
    modport slave  (input  addr, data, write, data32, write32, output data_out);
endinterface

// File: rtl/scan_counter_n.sv
// Multi-channel gated pulse counter: counts rising edges on count_in during a window opened by start_step.
// Latency: 3 cycles pin edge to count; results/time_out valid together with the result_valid pulse.
// No backpressure: bus writes are one-cycle strobes and are always accepted; reads are combinational.
// Ports: clock50Mhz, key_restart (async active-low), bus (scan_counter_n_if.slave), count_in,
//        start_step/stop_step strobes, busy, result_valid, time_out, signals_out.
// Build option: define SCAN_COUNTER_SAT_EN for saturating channel counters with sticky overflow (STATUS bit2).
module scan_counter_n #(
    parameter int         N_CH   = 4,
    parameter int         CNT_W  = 32,
    parameter int         TIME_W = 32,
    parameter logic [7:0] BASE   = 8'h40
) (
    input  logic              clock50Mhz,
    input  logic              key_restart,
    scan_counter_n_if.slave   bus,
    input  logic [N_CH-1:0]   count_in,
    input  logic              start_step,
    input  logic              stop_step,
    output logic              busy,
    output logic              result_valid,
    output logic [TIME_W-1:0] time_out,
    output logic [CNT_W-1:0]  signals_out
);
    localparam logic [7:0] A_CTRL = BASE;
    localparam logic [7:0] A_SEL  = BASE + 8'd1;
    localparam logic [7:0] A_WIN  = BASE + 8'd2;
    localparam logic [7:0] A_STAT = BASE + 8'd3;
    localparam logic [7:0] A_RES  = BASE + 8'd4;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_LATCH} state_t;

    state_t             state_q, state_d;
    logic               en_q, clr_q;
    logic [7:0]         sel_q;
    logic [TIME_W-1:0]  win_q, win_sh_q, time_q, time_res_q;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   res_q [N_CH];
    logic [N_CH-1:0]    sync1_q, sync2_q, sync3_q;
    logic [N_CH-1:0]    edge_w, inc_w;
    logic               result_ready_q, result_valid_q;
    logic               start_go, close_win, busy_w, latch_w, ovf_any;
    logic [2:0]         ch_sel;
    logic [CNT_W-1:0]   sig_w;
    logic [31:0]        rd_word;
    logic [7:0]         rd_dat;

    // Register writes. CLR is a one-cycle pulse so latched results clear the cycle after the write.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            en_q  <= 1'b0;
            clr_q <= 1'b0;
            sel_q <= '0;
            win_q <= '0;
        end else begin
            clr_q <= bus.write && (bus.addr == A_CTRL) && bus.data[1];
            if (bus.write && (bus.addr == A_CTRL)) en_q  <= bus.data[0];
            if (bus.write && (bus.addr == A_SEL))  sel_q <= bus.data;
            if (bus.write32 && (bus.addr == A_WIN)) win_q <= TIME_W'(bus.data32);
        end
    end

    // 2-FF synchroniser plus one register for edge detection.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= count_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end
    assign edge_w = sync2_q & ~sync3_q;

    assign start_go  = (state_q == S_IDLE) && start_step && en_q && (win_q != '0);
    // Compared against the value shadowed at start so WIN writes only affect the next window.
    assign close_win = (time_q == (win_sh_q - TIME_W'(1))) || stop_step || !en_q;

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go)  state_d = S_COUNT;
            S_COUNT: if (close_win) state_d = S_LATCH;
            S_LATCH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_w  = (state_q == S_COUNT);
        latch_w = (state_q == S_LATCH);
    end

`ifdef SCAN_COUNTER_SAT_EN
    logic [N_CH-1:0] full_w;
    logic [N_CH-1:0] ovf_q;

    always_comb begin
        full_w = '0;
        inc_w  = '0;
        for (int i = 0; i < N_CH; i++) begin
            full_w[i] = (cnt_q[i] == {CNT_W{1'b1}});
            inc_w[i]  = busy_w && edge_w[i] && !full_w[i];
        end
    end

    // Sticky: an edge that would have wrapped a full counter.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart)            ovf_q <= '0;
        else if (clr_q || start_go)  ovf_q <= '0;
        else if (busy_w)             ovf_q <= ovf_q | (edge_w & full_w);
    end
    assign ovf_any = |ovf_q;
`else
    always_comb begin
        inc_w = '0;
        for (int i = 0; i < N_CH; i++) inc_w[i] = busy_w && edge_w[i];
    end
    assign ovf_any = 1'b0;
`endif

    // Live counters; the cycle the window closes still counts and still advances time.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            time_q   <= '0;
            win_sh_q <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (start_go) begin
            time_q   <= '0;
            win_sh_q <= win_q;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (busy_w) begin
            time_q <= time_q + TIME_W'(1);
            for (int i = 0; i < N_CH; i++)
                if (inc_w[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    // Latched results; a LATCH coinciding with a CLR keeps the fresh results.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            time_res_q     <= '0;
            result_ready_q <= 1'b0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
        end else begin
            result_valid_q <= latch_w;
            if (clr_q) begin
                time_res_q     <= '0;
                result_ready_q <= 1'b0;
                for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
            end
            if (start_go) result_ready_q <= 1'b0;
            if (latch_w) begin
                time_res_q     <= time_q;
                result_ready_q <= 1'b1;
                for (int i = 0; i < N_CH; i++) res_q[i] <= cnt_q[i];
            end
        end
    end

    // Channel select: out-of-range channel numbers fall back to channel 0.
    always_comb begin
        ch_sel = (int'(sel_q[2:0]) < N_CH) ? sel_q[2:0] : 3'd0;
        sig_w  = '0;
        for (int i = 0; i < N_CH; i++)
            if (ch_sel == 3'(i)) sig_w = res_q[i];
    end

    always_comb begin
        rd_word = 32'(sig_w);
        rd_dat  = 8'h00;
        case (bus.addr)
            A_CTRL: rd_dat = {7'b0, en_q};
            A_SEL:  rd_dat = sel_q;
            A_STAT: rd_dat = {5'b0, ovf_any, result_ready_q, busy_w};
            A_RES: begin
                case (sel_q[7:6])
                    2'd0:    rd_dat = rd_word[7:0];
                    2'd1:    rd_dat = rd_word[15:8];
                    2'd2:    rd_dat = rd_word[23:16];
                    default: rd_dat = rd_word[31:24];
                endcase
            end
            default: rd_dat = 8'h00;
        endcase
    end

    assign bus.data_out  = rd_dat;
    assign busy          = busy_w;
    assign result_valid  = result_valid_q;
    assign time_out      = time_res_q;
    assign signals_out   = sig_w;
endmodule

// File: tb/tb_scan_counter_n.sv
// Randomized bench for scan_counter_n against a window/timing reference model.
// Latency: model counts a pin rise first sampled at edge r if r+2 lies inside the counting edges.
// No backpressure on the bus; every wait is bounded by a cycle count.
module tb_scan_counter_n;
    localparam int         N_CH  = 4;
    localparam int         CNT_W = 8;
    localparam logic [7:0] BASE  = 8'h40;
    localparam logic [7:0] A_CTRL = BASE;
    localparam logic [7:0] A_SEL  = BASE + 8'd1;
    localparam logic [7:0] A_WIN  = BASE + 8'd2;
    localparam logic [7:0] A_STAT = BASE + 8'd3;
    localparam logic [7:0] A_RES  = BASE + 8'd4;
`ifdef SCAN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] count_in;
    logic            start_step, stop_step;
    logic            busy, result_valid;
    logic [31:0]     time_out;
    logic [CNT_W-1:0] signals_out;

    scan_counter_n_if bus_if ();

    scan_counter_n #(.N_CH(N_CH), .CNT_W(CNT_W), .TIME_W(32), .BASE(BASE)) dut (
        .clock50Mhz  (clk),
        .key_restart (rst_n),
        .bus         (bus_if),
        .count_in    (count_in),
        .start_step  (start_step),
        .stop_step   (stop_step),
        .busy        (busy),
        .result_valid(result_valid),
        .time_out    (time_out),
        .signals_out (signals_out)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_win = 0;
    bit m_en = 1'b0;
    int exp_cnt [N_CH];
    bit exp_ovf;
    int cap [N_CH];
    int dens;
    int hi [N_CH];
    int lo [N_CH];
    int made [N_CH];
    int rise_t [$];
    int rise_c [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus_if.addr = a; bus_if.data = d; bus_if.write = 1'b1;
        tick();
        bus_if.write = 1'b0;
        if (a == A_CTRL) m_en = d[0];
    endtask

    task automatic bus_wr32(input logic [7:0] a, input int v);
        bus_if.addr = a; bus_if.data32 = v; bus_if.write32 = 1'b1;
        tick();
        bus_if.write32 = 1'b0;
        if (a == A_WIN) m_win = v;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
        bus_if.addr = a;
        #1;
        v = bus_if.data_out;
    endtask

    task automatic set_gen(input int d, input int c0, input int c1, input int c2, input int c3);
        dens = d;
        cap[0] = c0; cap[1] = c1; cap[2] = c2; cap[3] = c3;
        for (int c = 0; c < N_CH; c++) begin hi[c] = 0; lo[c] = 2; made[c] = 0; end
        count_in = '0;
        rise_t.delete();
        rise_c.delete();
    endtask

    // Pulses are 2 cycles high, at least 2 low; the rise is first sampled at edge cyc+1.
    task automatic gen_step();
        for (int c = 0; c < N_CH; c++) begin
            if (count_in[c]) begin
                hi[c]--;
                if (hi[c] == 0) begin count_in[c] = 1'b0; lo[c] = 0; end
            end else begin
                lo[c]++;
                if (lo[c] >= 2 && made[c] < cap[c] && int'($urandom_range(99, 0)) < dens) begin
                    count_in[c] = 1'b1; hi[c] = 2; made[c]++;
                    rise_t.push_back(cyc + 1); rise_c.push_back(c);
                end
            end
        end
    endtask

    task automatic run_window(input string tag, input int stop_k, input int restart_k, input int wr_k,
                              input logic [7:0] wr_addr, input int wr_val, input bit wr_is32, input bit pre3);
        int s, L, k, busy_seen, rv_seen, rv_at;
        int raw [N_CH];
        logic [7:0] v;
        busy_seen = 0; rv_seen = 0; rv_at = -1;
        if (pre3) begin
            count_in[3] = 1'b1; hi[3] = 2;
            rise_t.push_back(cyc + 1); rise_c.push_back(3);
            tick();
        end
        s = cyc + 1;
        L = m_win;
        if (stop_k > 0 && stop_k < L) L = stop_k;
        if (wr_k > 0 && !wr_is32 && wr_addr == A_CTRL && wr_val[0] == 1'b0 && wr_k + 1 < L) L = wr_k + 1;
        start_step = 1'b1;
        bus_if.addr = A_STAT;
        gen_step();
        tick();
        while (cyc <= s + L + 3) begin
            if (busy) busy_seen++;
            if (result_valid) begin rv_seen++; rv_at = cyc; end
            if (cyc == s) chk({tag, "_status_in_win"}, bus_if.data_out, 8'h01);
            k = cyc + 1 - s;
            start_step = (restart_k != 0 && k == restart_k);
            stop_step  = (stop_k != 0 && k == stop_k);
            if (wr_k != 0 && k == wr_k) begin
                bus_if.addr = wr_addr;
                if (wr_is32) begin bus_if.data32 = wr_val; bus_if.write32 = 1'b1; end
                else begin bus_if.data = wr_val[7:0]; bus_if.write = 1'b1; end
            end else begin
                bus_if.addr = A_STAT; bus_if.write = 1'b0; bus_if.write32 = 1'b0;
            end
            gen_step();
            tick();
        end
        start_step = 1'b0; stop_step = 1'b0; count_in = '0;
        if (wr_k != 0) begin
            if (wr_is32 && wr_addr == A_WIN) m_win = wr_val;
            if (!wr_is32 && wr_addr == A_CTRL) m_en = wr_val[0];
        end
        for (int c = 0; c < N_CH; c++) raw[c] = 0;
        foreach (rise_t[j])
            if (rise_t[j] + 2 >= s + 1 && rise_t[j] + 2 <= s + L) raw[rise_c[j]]++;
        exp_ovf = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (raw[c] >= (1 << CNT_W)) begin
                if (SAT) begin exp_cnt[c] = (1 << CNT_W) - 1; exp_ovf = 1'b1; end
                else exp_cnt[c] = raw[c] % (1 << CNT_W);
            end else exp_cnt[c] = raw[c];
        end
        chk({tag, "_busy_cycles"}, busy_seen, L);
        chk({tag, "_rv_pulses"}, rv_seen, 1);
        chk({tag, "_rv_cycle"}, rv_at - s, L + 1);
        chk({tag, "_time_out"}, time_out, L);
        for (int c = 0; c < N_CH; c++) begin
            bus_wr(A_SEL, 8'(c));
            chk($sformatf("%s_cnt%0d", tag, c), signals_out, exp_cnt[c]);
            read_reg(A_RES, v);
            chk($sformatf("%s_rd%0d", tag, c), v, exp_cnt[c]);
        end
        read_reg(A_STAT, v);
        chk({tag, "_status_after"}, v, {5'b0, exp_ovf, 1'b1, 1'b0});
    endtask

    task automatic ignored_start(input string tag);
        int busy_seen, rv_seen;
        busy_seen = 0; rv_seen = 0;
        start_step = 1'b1;
        tick();
        start_step = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_seen++;
            if (result_valid) rv_seen++;
            tick();
        end
        chk({tag, "_busy"}, busy_seen, 0);
        chk({tag, "_rv"}, rv_seen, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int w, sk, rk, busy_seen, rv_seen;
        rst_n = 1'b0;
        count_in = '0; start_step = 1'b0; stop_step = 1'b0;
        bus_if.addr = A_STAT; bus_if.data = '0; bus_if.write = 1'b0;
        bus_if.data32 = '0; bus_if.write32 = 1'b0;
        for (int c = 0; c < N_CH; c++) exp_cnt[c] = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_time", time_out, 0);
        chk("rst_signals", signals_out, 0);
        chk("rst_status", bus_if.data_out, 0);
        rst_n = 1'b1;
        tick();
        read_reg(BASE + 8'd5, v);
        chk("rd_out_of_range_idle", v, 8'h00);

        // Basic window: period-4 pulses, 250 on ch0 and 17 on ch2.
        bus_wr(A_CTRL, 8'h01);
        bus_wr32(A_WIN, 1000);
        set_gen(100, 250, 0, 17, 0);
        run_window("basic", 0, 0, 0, 8'h00, 0, 1'b0, 1'b0);
        read_reg(BASE + 8'd5, v);
        chk("rd_out_of_range", v, 8'h00);
        // Channel number beyond N_CH reads back as written and selects channel 0.
        bus_wr(A_SEL, 8'h05);
        chk("sel_oob_ch0", signals_out, exp_cnt[0]);
        read_reg(A_SEL, v);
        chk("sel_oob_readback", v, 8'h05);

        bus_wr32(A_WIN, 5000);
        set_gen(40, 1000, 1000, 1000, 1000);
        run_window("early_stop", 300, 0, 0, 8'h00, 0, 1'b0, 1'b0);

        bus_wr(A_CTRL, 8'h00);
        bus_wr32(A_WIN, 50);
        ignored_start("start_en0");
        bus_wr(A_CTRL, 8'h01);
        bus_wr32(A_WIN, 0);
        ignored_start("start_win0");

        bus_wr32(A_WIN, 200);
        set_gen(60, 1000, 1000, 1000, 1000);
        run_window("restart_ignored", 0, 50, 0, 8'h00, 0, 1'b0, 1'b0);

        bus_wr32(A_WIN, 1);
        set_gen(100, 0, 0, 0, 0);
        run_window("win1", 0, 0, 0, 8'h00, 0, 1'b0, 1'b1);

        // WIN change mid-window only applies to the next window.
        bus_wr32(A_WIN, 100);
        set_gen(50, 1000, 1000, 1000, 1000);
        run_window("win_shadow", 0, 0, 10, A_WIN, 37, 1'b1, 1'b0);
        set_gen(50, 1000, 1000, 1000, 1000);
        run_window("win_next", 0, 0, 0, 8'h00, 0, 1'b0, 1'b0);

        bus_wr32(A_WIN, 80);
        set_gen(70, 1000, 1000, 1000, 1000);
        run_window("clr_in_win", 0, 0, 5, A_CTRL, 3, 1'b0, 1'b0);
        set_gen(70, 1000, 1000, 1000, 1000);
        run_window("en_off", 0, 0, 20, A_CTRL, 0, 1'b0, 1'b0);
        bus_wr(A_CTRL, 8'h01);

        bus_wr32(A_WIN, 1300);
        set_gen(100, 0, 300, 0, 0);
        run_window("overflow", 0, 0, 0, 8'h00, 0, 1'b0, 1'b0);
        bus_wr(A_CTRL, 8'h03);
        tick();
        read_reg(A_STAT, v);
        chk("clr_status", v, 8'h00);
        chk("clr_signals", signals_out, 0);
        chk("clr_time", time_out, 0);

        for (int it = 0; it < 6; it++) begin
            w = int'($urandom_range(300, 1));
            bus_wr32(A_WIN, w);
            sk = ($urandom_range(1, 0) == 1) ? int'($urandom_range(350, 1)) : 0;
            rk = 0;
            if (w > 2 && $urandom_range(2, 0) == 0) begin
                rk = int'($urandom_range(w - 1, 1));
                if (sk != 0 && rk >= sk) rk = 0;
            end
            set_gen(int'($urandom_range(100, 5)), 1000, 1000, 1000, 1000);
            run_window($sformatf("rand%0d", it), sk, rk, 0, 8'h00, 0, 1'b0, 1'b0);
        end

        // Reset mid-window: everything clears at once and no result_valid follows.
        bus_wr32(A_WIN, 500);
        start_step = 1'b1;
        tick();
        start_step = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        bus_if.addr = A_STAT;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_time", time_out, 0);
        chk("rst_mid_signals", signals_out, 0);
        chk("rst_mid_status", bus_if.data_out, 0);
        busy_seen = 0; rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) busy_seen++;
            if (result_valid) rv_seen++;
        end
        rst_n = 1'b1;
        m_en = 1'b0; m_win = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) busy_seen++;
            if (result_valid) rv_seen++;
        end
        chk("rst_mid_no_busy", busy_seen, 0);
        chk("rst_mid_no_rv", rv_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
